// File: rtl/char_buffer_arbiter_pkg.sv
// Shared geometry, character codes and encodings for the 12x9 text buffer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package char_buffer_arbiter_pkg;

    localparam int BUF_W  = 12;
    localparam int BUF_H  = 9;
    localparam int ADDR_W = 7;

    localparam logic [ADDR_W-1:0] BUF_W_A   = ADDR_W'(BUF_W);
    localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'(BUF_H - 1);
    localparam logic [ADDR_W-1:0] BUF_CELLS = ADDR_W'(BUF_W * BUF_H);
    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(BUF_W * BUF_H - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    localparam logic [7:0] CLEAR_CHAR  = 8'h20;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_NUL   = 8'h00;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    // Identifies which source received the most recent grant.
    typedef enum logic {
        SRC_CPU = 1'b0,
        SRC_KB  = 1'b1
    } src_e;

endpackage

// File: rtl/char_buffer_arbiter_cursor_unit.sv
// Next-cursor and write request for one keyboard byte (printable, BS or LF).
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is committed.
module cursor_unit
    import char_buffer_arbiter_pkg::*;
(
    input  logic [ADDR_W-1:0] cursor_i,
    input  logic [7:0]        char_i,
    output logic [ADDR_W-1:0] nxt_cursor_o,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [7:0]        data_o
);

    logic [ADDR_W-1:0] row;

    // Decode the byte: backspace erases behind the cursor, LF jumps rows, anything else prints.
    always_comb begin
        row          = '0;
        nxt_cursor_o = cursor_i;
        we_o         = 1'b0;
        addr_o       = cursor_i;
        data_o       = char_i;
        if (char_i == ASCII_BS) begin
            // Backspace at the home cell is a no-op rather than wrapping to the end.
            if (cursor_i != '0) begin
                nxt_cursor_o = cursor_i - ADDR_ONE;
                we_o         = 1'b1;
                addr_o       = cursor_i - ADDR_ONE;
                data_o       = CLEAR_CHAR;
            end
        end else if (char_i == ASCII_LF) begin
            row = cursor_i / BUF_W_A;
            if (row == LAST_ROW) begin
                nxt_cursor_o = '0;
            end else begin
                nxt_cursor_o = (row + ADDR_ONE) * BUF_W_A;
            end
        end else begin
            we_o         = 1'b1;
            nxt_cursor_o = (cursor_i == LAST_CELL) ? '0 : cursor_i + ADDR_ONE;
        end
    end

endmodule

// File: rtl/char_buffer_arbiter.sv
// Single write port for the text buffer: arbitrates keyboard, CPU and clear sweep; owns the cursor.
// Latency: write port and cpu_ack registered, valid the cycle after the grant.
// Backpressure: kb_ready low while a byte is held; cpu_req held until cpu_ack; sweep defers both.
module char_buffer_arbiter
    import char_buffer_arbiter_pkg::*;
(
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              kb_valid_i,
    input  logic [7:0]        kb_char_i,
    output logic              kb_ready_o,
    input  logic              cpu_req_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [7:0]        cpu_data_i,
    output logic              cpu_ack_o,
    input  logic              clr_req_i,
    output logic              clr_busy_o,
    output logic              buf_we_o,
    output logic [ADDR_W-1:0] buf_addr_o,
    output logic [7:0]        buf_data_o,
    output logic [ADDR_W-1:0] cursor_o
);

    state_e            state_q, state_d;
    src_e              rr_last_q, rr_last_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] cursor_q, cursor_d;
    logic              kb_full_q, kb_full_d;
    logic [7:0]        kb_hold_q, kb_hold_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              clr_busy_q, clr_busy_d;
    logic              buf_we_q, buf_we_d;
    logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
    logic [7:0]        buf_data_q, buf_data_d;

    logic              cpu_pend;
    logic              grant_kb;
    logic [ADDR_W-1:0] cu_nxt;
    logic              cu_we;
    logic [ADDR_W-1:0] cu_addr;
    logic [7:0]        cu_data;

    cursor_unit u_cursor (
        .cursor_i     (cursor_q),
        .char_i       (kb_hold_q),
        .nxt_cursor_o (cu_nxt),
        .we_o         (cu_we),
        .addr_o       (cu_addr),
        .data_o       (cu_data)
    );

    // A request still high during its own ack cycle is the old one and must not be served twice.
    assign cpu_pend = cpu_req_i & ~cpu_ack_q;

    // Next-state: holding register, sweep, round-robin grant and the registered write port.
    always_comb begin
        state_d    = state_q;
        rr_last_d  = rr_last_q;
        cnt_d      = cnt_q;
        cursor_d   = cursor_q;
        kb_full_d  = kb_full_q;
        kb_hold_d  = kb_hold_q;
        cpu_ack_d  = 1'b0;
        clr_busy_d = (state_q == ST_CLEAR);
        buf_we_d   = 1'b0;
        buf_addr_d = buf_addr_q;
        buf_data_d = buf_data_q;
        grant_kb   = 1'b0;

        // NUL from the scancode lookup means "no character" and is swallowed on accept.
        if (kb_valid_i && !kb_full_q && (kb_char_i != ASCII_NUL)) begin
            kb_full_d = 1'b1;
            kb_hold_d = kb_char_i;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (clr_req_i) begin
                    state_d    = ST_CLEAR;
                    cnt_d      = '0;
                    clr_busy_d = 1'b1;
                end else if (cpu_pend || kb_full_q) begin
                    grant_kb = kb_full_q && (!cpu_pend || (rr_last_q == SRC_CPU));
                    if (grant_kb) begin
                        rr_last_d  = SRC_KB;
                        kb_full_d  = 1'b0;
                        cursor_d   = cu_nxt;
                        buf_we_d   = cu_we;
                        if (cu_we) begin
                            buf_addr_d = cu_addr;
                            buf_data_d = cu_data;
                        end
                    end else begin
                        rr_last_d = SRC_CPU;
                        cpu_ack_d = 1'b1;
                        // Out-of-range targets are acknowledged but never reach the buffer.
                        if (cpu_addr_i < BUF_CELLS) begin
                            buf_we_d   = 1'b1;
                            buf_addr_d = cpu_addr_i;
                            buf_data_d = cpu_data_i;
                        end
                    end
                end
            end
            ST_CLEAR: begin
                buf_we_d   = 1'b1;
                buf_addr_d = cnt_q;
                buf_data_d = CLEAR_CHAR;
                if (cnt_q == LAST_CELL) begin
                    state_d  = ST_IDLE;
                    cursor_d = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset abandons any sweep and drops a held byte.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            rr_last_q  <= SRC_CPU;
            cnt_q      <= '0;
            cursor_q   <= '0;
            kb_full_q  <= 1'b0;
            kb_hold_q  <= '0;
            cpu_ack_q  <= 1'b0;
            clr_busy_q <= 1'b0;
            buf_we_q   <= 1'b0;
            buf_addr_q <= '0;
            buf_data_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_last_q  <= rr_last_d;
            cnt_q      <= cnt_d;
            cursor_q   <= cursor_d;
            kb_full_q  <= kb_full_d;
            kb_hold_q  <= kb_hold_d;
            cpu_ack_q  <= cpu_ack_d;
            clr_busy_q <= clr_busy_d;
            buf_we_q   <= buf_we_d;
            buf_addr_q <= buf_addr_d;
            buf_data_q <= buf_data_d;
        end
    end

    assign kb_ready_o = ~kb_full_q;
    assign cpu_ack_o  = cpu_ack_q;
    assign clr_busy_o = clr_busy_q;
    assign buf_we_o   = buf_we_q;
    assign buf_addr_o = buf_addr_q;
    assign buf_data_o = buf_data_q;
    assign cursor_o   = cursor_q;

endmodule
